pcs_descrambler_mlane: RTL and testbench
========================================

// Module: pcs_descrambler_mlane
// PURPOSE
//  Multi-lane self-synchronising 64b/66b descrambler, polynomial x^58+x^39+1, one lane per 64-bit payload.
//  Sits between block-sync/gearbox and the 66b block decoder.
//  Adds per-lane scrambler-lock monitoring on idle control blocks, plus a saturating error counter per lane.
// PARAMETERS
//  LANES      1   number of independent lanes
//  LOCK_GOOD  4   consecutive good idle blocks to enter LOCKED (>=1)
//  UNLOCK_BAD 3   consecutive bad idle blocks to leave LOCKED (>=1)
//  CNT_W      16  width of per-lane error counter
// PORTS
//  CLK              in   1          clock
//  RST              in   1          synchronous, active-high reset
//  CSR_DESCRAMB_DIS in   1          bypass (async level, 2-flop synchronised internally)
//  CSR_ERR_CLR      in   1          clear all ERR_CNT (CLK-domain pulse)
//  DIN              in   LANES*64   scrambled payload; lane n = [64n+63:64n], bit 0 first on wire
//  DIN_SH           in   LANES*2    sync header per lane
//  DIN_EN           in   LANES      payload valid per lane
//  DIN_BLOCK_SYNC   in   LANES      block-sync achieved per lane
//  DOUT             out  LANES*64   descrambled payload
//  DOUT_SH          out  LANES*2    delayed sync header
//  DOUT_EN          out  LANES      delayed valid
//  DOUT_BLOCK_SYNC  out  LANES      delayed block sync
//  DESCR_LOCK       out  LANES      1 = lane in LOCKED state
//  ERR_CNT          out  LANES*CNT_W bad-idle count per lane, saturating
// BEHAVIOUR
//  Reset: all outputs 0; lane state s = 58'h3FF_FFFF_FFFF_FFFF (all ones); monitor HUNT, counts 0.
//  Lanes are fully independent except the shared bypass and clear.
//  Descramble: h = {DIN_lane, s}.
//   - out[i] = h[i+58] ^ h[i+19] ^ h[i], for i = 0..63.
//   - On DIN_EN: s <= h[121:64].
//   - DIN_EN low: s holds, output register holds.
//  Sync loss: DIN_BLOCK_SYNC=0 in a cycle takes priority over DIN_EN.
//   - Same cycle: s <= all ones and stage-1 data <= 0.
//   - Output regs DOUT/SH/EN/BLOCK_SYNC <= 0 the next cycle.
//  Latency: exactly 2 cycles DIN -> DOUT. DOUT_SH, DOUT_EN and DOUT_BLOCK_SYNC are delayed 2 cycles to stay aligned.
//  Bypass: synchronised DIS=1 -> DOUT = DIN delayed 2 cycles. s still updates, so re-enabling needs no resync.
//  Idle check, evaluated on a registered output beat with DOUT_EN=1 & DOUT_BLOCK_SYNC=1 & DOUT_SH=2'b10 & DOUT[7:0]=8'h1E:
//   - good idle: DOUT[63:8]==0.
//   - bad idle: any other value.
//   - All other beats leave the counters unchanged.
//  Monitor FSM (per lane), registered; DESCR_LOCK updates the cycle after the qualifying beat:
//   - HUNT: good -> gcnt+1; gcnt reaching LOCK_GOOD -> LOCKED and gcnt=0. Bad -> gcnt=0.
//   - LOCKED: bad -> bcnt+1; bcnt reaching UNLOCK_BAD -> HUNT and bcnt=0. Good -> bcnt=0.
//   - DIN_BLOCK_SYNC=0 -> HUNT with gcnt=bcnt=0.
//   - The monitor runs in bypass too, so scrambled traffic in bypass drops lock.
//  ERR_CNT: +1 per bad idle, saturates at all ones.
//   - CSR_ERR_CLR wins over a same-cycle increment (result 0).
//   - ERR_CNT is not cleared by sync loss; it is cleared only by RST or CSR_ERR_CLR.
//  Reset mid-stream: next cycle all outputs 0 and s all ones, regardless of DIN_EN.
// TESTING
//  1. Bench scrambler seeded all ones, 10 idle blocks (SH=10, payload 64'h1E) on lane 0
//     -> DOUT=64'h1E from cycle 2; DESCR_LOCK=1 one cycle after the 4th good beat; ERR_CNT=0.
//  2. Once LOCKED, flip DIN bit 20 on 3 consecutive idle blocks
//     -> DESCR_LOCK=0 after the 3rd bad beat; ERR_CNT counts all bad idle beats.
//     A data block between the bad idles does not reset bcnt; a good idle does.
//  3. Deassert DIN_BLOCK_SYNC for 1 cycle mid-stream
//     -> DOUT/EN/SH=0 next cycle; DESCR_LOCK=0; s reseeds so bench rescrambles from all ones.
//  4. CSR_DESCRAMB_DIS=1, DIN=64'hDEADBEEF_01234567
//     -> same value on DOUT 2 cycles after the synchroniser settles; lock drops on scrambled idles.
//  5. CNT_W=4: 20 bad idles, CSR_ERR_CLR on the same cycle as the 20th
//     -> saturates at 4'hF, then reads 0; DIN_EN gaps hold s (output matches a gapless reference).
//  6. LANES=4: independent streams per lane, sync dropped on lane 2 only
//     -> lanes 0, 1 and 3 are unaffected and stay bit-exact versus the model.

Source files
------------

// File: rtl/pcs_descrambler_mlane.sv
// Multi-lane self-synchronising 64b/66b descrambler (x^58 + x^39 + 1) with
// per-lane idle-block lock monitor and saturating bad-idle counter.
module pcs_descrambler_mlane #(
  parameter int LANES      = 1,
  parameter int LOCK_GOOD  = 4,
  parameter int UNLOCK_BAD = 3,
  parameter int CNT_W      = 16
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   CSR_DESCRAMB_DIS,
  input  logic                   CSR_ERR_CLR,
  input  logic [LANES*64-1:0]    DIN,
  input  logic [LANES*2-1:0]     DIN_SH,
  input  logic [LANES-1:0]       DIN_EN,
  input  logic [LANES-1:0]       DIN_BLOCK_SYNC,
  output logic [LANES*64-1:0]    DOUT,
  output logic [LANES*2-1:0]     DOUT_SH,
  output logic [LANES-1:0]       DOUT_EN,
  output logic [LANES-1:0]       DOUT_BLOCK_SYNC,
  output logic [LANES-1:0]       DESCR_LOCK,
  output logic [LANES*CNT_W-1:0] ERR_CNT
);

  localparam int GW = $clog2(LOCK_GOOD + 1);
  localparam int BW = $clog2(UNLOCK_BAD + 1);

  typedef enum logic {HUNT, LOCKED} mon_state_t;

  logic             dis_meta, dis_sync;
  logic [63:0]      dout_q [LANES];
  logic [1:0]       sh_q   [LANES];
  logic             en_q   [LANES];
  logic             bs_q   [LANES];
  logic             lock_q [LANES];
  logic [CNT_W-1:0] err_q  [LANES];

  // NOTE: every clocked process uses non-blocking (<=) so all registers sample
  // pre-edge values; blocking here would chain stage 1 straight into stage 2.
  always_ff @(posedge CLK) begin
    if (RST) begin
      dis_meta <= 1'b0;
      dis_sync <= 1'b0;
    end else begin
      dis_meta <= CSR_DESCRAMB_DIS;
      dis_sync <= dis_meta;
    end
  end

  for (genvar n = 0; n < LANES; n++) begin : g_lane
    logic [63:0]      din_l;
    logic [1:0]       sh_l;
    logic             en_l, bs_l;
    logic [57:0]      s;
    logic [121:0]     h;
    logic [63:0]      descr;
    logic [63:0]      d1;
    logic [1:0]       sh1;
    logic             en1, bs1;
    logic             qual, good;
    mon_state_t       st, st_nx;
    logic [GW-1:0]    gcnt, gcnt_nx;
    logic [BW-1:0]    bcnt, bcnt_nx;
    logic [CNT_W-1:0] ecnt_nx;

    assign din_l = DIN[64*n +: 64];
    assign sh_l  = DIN_SH[2*n +: 2];
    assign en_l  = DIN_EN[n];
    assign bs_l  = DIN_BLOCK_SYNC[n];

    // s[0] is the oldest received bit; h is the 122-bit window ending at din_l[63].
    assign h = {din_l, s};

    always_comb begin
      descr = '0;
      for (int i = 0; i < 64; i++) descr[i] = h[i+58] ^ h[i+19] ^ h[i];
    end

    // Stage 1: the descrambler state advances on valid beats even in bypass.
    always_ff @(posedge CLK) begin
      if (RST || !bs_l) begin
        s   <= '1;
        d1  <= '0;
        sh1 <= '0;
        en1 <= 1'b0;
        bs1 <= 1'b0;
      end else begin
        en1 <= en_l;
        bs1 <= 1'b1;
        if (en_l) begin
          s   <= h[121:64];
          d1  <= dis_sync ? din_l : descr;
          sh1 <= sh_l;
        end
      end
    end

    always_ff @(posedge CLK) begin
      if (RST) begin
        dout_q[n] <= '0;
        sh_q[n]   <= '0;
        en_q[n]   <= 1'b0;
        bs_q[n]   <= 1'b0;
      end else begin
        dout_q[n] <= d1;
        sh_q[n]   <= sh1;
        en_q[n]   <= en1;
        bs_q[n]   <= bs1;
      end
    end

    assign qual = en_q[n] && bs_q[n] && (sh_q[n] == 2'b10) && (dout_q[n][7:0] == 8'h1E);
    assign good = (dout_q[n][63:8] == 56'd0);

    // NOTE: all next-state outputs take their hold value first so no path
    // through this block can leave a signal unassigned and infer a latch.
    always_comb begin
      st_nx   = st;
      gcnt_nx = gcnt;
      bcnt_nx = bcnt;
      ecnt_nx = err_q[n];
      if (CSR_ERR_CLR)
        ecnt_nx = '0;
      else if (qual && !good && (err_q[n] != '1))
        ecnt_nx = err_q[n] + CNT_W'(1);
      if (!bs_l) begin
        st_nx   = HUNT;
        gcnt_nx = '0;
        bcnt_nx = '0;
      end else if (qual) begin
        case (st)
          HUNT: begin
            if (!good)                           gcnt_nx = '0;
            else if (gcnt == GW'(LOCK_GOOD - 1)) begin
              st_nx   = LOCKED;
              gcnt_nx = '0;
            end else                             gcnt_nx = gcnt + GW'(1);
          end
          LOCKED: begin
            if (good)                             bcnt_nx = '0;
            else if (bcnt == BW'(UNLOCK_BAD - 1)) begin
              st_nx   = HUNT;
              bcnt_nx = '0;
            end else                              bcnt_nx = bcnt + BW'(1);
          end
          default: st_nx = HUNT;
        endcase
      end
    end

    always_ff @(posedge CLK) begin
      if (RST) begin
        st       <= HUNT;
        gcnt     <= '0;
        bcnt     <= '0;
        err_q[n] <= '0;
      end else begin
        st       <= st_nx;
        gcnt     <= gcnt_nx;
        bcnt     <= bcnt_nx;
        err_q[n] <= ecnt_nx;
      end
    end

    assign lock_q[n] = (st == LOCKED);
  end

  always_comb begin
    DOUT            = '0;
    DOUT_SH         = '0;
    DOUT_EN         = '0;
    DOUT_BLOCK_SYNC = '0;
    DESCR_LOCK      = '0;
    ERR_CNT         = '0;
    for (int n = 0; n < LANES; n++) begin
      DOUT[64*n +: 64]          = dout_q[n];
      DOUT_SH[2*n +: 2]         = sh_q[n];
      DOUT_EN[n]                = en_q[n];
      DOUT_BLOCK_SYNC[n]        = bs_q[n];
      DESCR_LOCK[n]             = lock_q[n];
      ERR_CNT[CNT_W*n +: CNT_W] = err_q[n];
    end
  end

endmodule

// File: tb/tb_pcs_descrambler_mlane.sv
// Bench for pcs_descrambler_mlane: bit-serial reference scrambler on the send
// side, expected beats queued at drive time and popped two cycles later.
module tb_pcs_descrambler_mlane;

  localparam int L  = 4;
  localparam int CW = 4;
  localparam int LG = 4;
  localparam int UB = 3;

  localparam logic [63:0] IDLE = 64'h0000_0000_0000_001E;
  localparam logic [63:0] BAD  = 64'h0000_0000_0010_001E;
  localparam logic [63:0] DATA = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] BYPW = 64'hDEAD_BEEF_0123_4567;
  localparam logic [63:0] LOOK = 64'hA5A5_A5A5_A5A5_A51E;

  typedef struct packed {
    logic [L*64-1:0] d;
    logic [L*2-1:0]  sh;
    logic [L-1:0]    en;
    logic [L-1:0]    bs;
  } beat_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst, dis, clr;
  logic [L*64-1:0] din;
  logic [L*2-1:0]  din_sh;
  logic [L-1:0]    din_en, din_bs;
  logic [L*64-1:0] dout;
  logic [L*2-1:0]  dout_sh;
  logic [L-1:0]    dout_en, dout_bs, lock;
  logic [L*CW-1:0] err_cnt;

  pcs_descrambler_mlane #(.LANES(L), .LOCK_GOOD(LG), .UNLOCK_BAD(UB), .CNT_W(CW)) dut (
    .CLK              (clk),
    .RST              (rst),
    .CSR_DESCRAMB_DIS (dis),
    .CSR_ERR_CLR      (clr),
    .DIN              (din),
    .DIN_SH           (din_sh),
    .DIN_EN           (din_en),
    .DIN_BLOCK_SYNC   (din_bs),
    .DOUT             (dout),
    .DOUT_SH          (dout_sh),
    .DOUT_EN          (dout_en),
    .DOUT_BLOCK_SYNC  (dout_bs),
    .DESCR_LOCK       (lock),
    .ERR_CNT          (err_cnt)
  );

  beat_t           sb[$];
  beat_t           cur;
  logic [57:0]     tx_s    [L];
  logic [63:0]     pend    [L];
  logic [63:0]     last_d  [L];
  logic [1:0]      last_sh [L];
  int              gcnt    [L];
  int              bcnt    [L];
  logic [L-1:0]    lock_m;
  logic [L*CW-1:0] err_m;
  logic            byp;
  logic [L*64-1:0] rp;
  int              n_chk, n_fail;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Transmit-side scrambler, one bit at a time: c[i] = d[i] ^ c[i-39] ^ c[i-58].
  function automatic logic [121:0] scramble(input logic [63:0] p, input logic [57:0] st);
    logic [121:0] hh;
    hh = {64'd0, st};
    for (int i = 0; i < 64; i++) hh[i+58] = p[i] ^ hh[i+19] ^ hh[i];
    return hh;
  endfunction

  // Lock/counter expectations from the beat currently on DOUT and this cycle's inputs.
  task automatic model_monitor(input logic [L-1:0] bs, input logic c);
    for (int n = 0; n < L; n++) begin
      logic [63:0] d;
      logic        q, g;
      d = cur.d[64*n +: 64];
      q = cur.en[n] && cur.bs[n] && (cur.sh[2*n +: 2] == 2'b10) && (d[7:0] == 8'h1E);
      g = (d[63:8] == 56'd0);
      if (c)
        err_m[CW*n +: CW] = '0;
      else if (q && !g && (err_m[CW*n +: CW] != {CW{1'b1}}))
        err_m[CW*n +: CW] = err_m[CW*n +: CW] + 1'b1;
      if (!bs[n]) begin
        lock_m[n] = 1'b0;
        gcnt[n]   = 0;
        bcnt[n]   = 0;
      end else if (q) begin
        if (!lock_m[n]) begin
          if (g) begin
            gcnt[n]++;
            if (gcnt[n] == LG) begin lock_m[n] = 1'b1; gcnt[n] = 0; end
          end else gcnt[n] = 0;
        end else begin
          if (!g) begin
            bcnt[n]++;
            if (bcnt[n] == UB) begin lock_m[n] = 1'b0; bcnt[n] = 0; end
          end else bcnt[n] = 0;
        end
      end
    end
  endtask

  // One clock: drive plaintext (scrambled here unless bypassed), queue the
  // expected beat, then compare the beat the DUT presents after the edge.
  task automatic cyc(input logic [L*64-1:0] plain, input logic [1:0] sh, input logic [L-1:0] en,
                     input logic [L-1:0] bs, input logic [L-1:0] flip, input logic c);
    beat_t        e;
    logic [121:0] hh;
    e = '0;
    for (int n = 0; n < L; n++) begin
      logic [63:0] p, w;
      p = plain[64*n +: 64];
      w = {$urandom(), $urandom()};
      if (!bs[n]) begin
        tx_s[n] = '1; pend[n] = '0; last_d[n] = '0; last_sh[n] = '0;
      end else if (en[n]) begin
        if (byp) begin
          w = p; tx_s[n] = p[63:6]; last_d[n] = p; pend[n] = '0;
        end else begin
          hh = scramble(p, tx_s[n]);
          w = hh[121:58];
          tx_s[n] = hh[121:64];
          last_d[n] = p ^ pend[n];
          pend[n] = '0;
          // A line error on bit 20 hits plaintext bits 20 and 59 now and bit 14 of the next block.
          if (flip[n]) begin
            w[20] = ~w[20];
            last_d[n] = last_d[n] ^ 64'h0800_0000_0010_0000;
            pend[n] = 64'h0000_0000_0000_4000;
          end
        end
        last_sh[n] = sh;
      end
      e.d[64*n +: 64] = last_d[n];
      e.sh[2*n +: 2]  = last_sh[n];
      e.en[n]         = en[n] & bs[n];
      e.bs[n]         = bs[n];
      din[64*n +: 64] = w;
      din_sh[2*n +: 2] = sh;
    end
    din_en = en;
    din_bs = bs;
    clr    = c;
    sb.push_back(e);
    model_monitor(bs, c);
    @(posedge clk); #1;
    cur = sb.pop_front();
    check("dout",    256'(dout),    256'(cur.d));
    check("dout_sh", 256'(dout_sh), 256'(cur.sh));
    check("dout_en", 256'(dout_en), 256'(cur.en));
    check("dout_bs", 256'(dout_bs), 256'(cur.bs));
    check("lock",    256'(lock),    256'(lock_m));
    check("err_cnt", 256'(err_cnt), 256'(err_m));
  endtask

  task automatic do_reset();
    rst = 1'b1; dis = 1'b0; clr = 1'b0;
    din = {L{64'h1234_5678_9ABC_DEF0}}; din_sh = {L{2'b10}}; din_en = '1; din_bs = '1;
    @(posedge clk); #1;
    check("rst_dout",    256'(dout),    256'(0));
    check("rst_dout_sh", 256'(dout_sh), 256'(0));
    check("rst_dout_en", 256'(dout_en), 256'(0));
    check("rst_dout_bs", 256'(dout_bs), 256'(0));
    check("rst_lock",    256'(lock),    256'(0));
    check("rst_err",     256'(err_cnt), 256'(0));
    rst = 1'b0;
    sb.delete();
    cur = '0;
    sb.push_back('0);
    lock_m = '0; err_m = '0; byp = 1'b0;
    for (int n = 0; n < L; n++) begin
      tx_s[n] = '1; pend[n] = '0; last_d[n] = '0; last_sh[n] = '0; gcnt[n] = 0; bcnt[n] = 0;
    end
  endtask

  initial begin
    n_chk = 0; n_fail = 0;
    do_reset();

    // Idle stream from an all-ones seed: first idle out after two clocks, lock after four good.
    for (int i = 1; i <= 10; i++) begin
      cyc({L{IDLE}}, 2'b10, '1, '1, '0, 1'b0);
      if (i == 2) check("first_idle", 256'(dout[63:0]), 256'(IDLE));
      if (i == 5) check("lock_pre",   256'(lock), 256'(4'b0000));
      if (i == 6) check("lock_post",  256'(lock), 256'(4'b1111));
    end

    // Lane 0 line errors: data between bad idles keeps bcnt, a good idle clears it.
    cyc({L{IDLE}}, 2'b10, '1, '1, 4'b0001, 1'b0);
    cyc({L{DATA}}, 2'b01, '1, '1, '0, 1'b0);
    cyc({L{IDLE}}, 2'b10, '1, '1, 4'b0001, 1'b0);
    cyc({L{DATA}}, 2'b01, '1, '1, '0, 1'b0);
    cyc({L{IDLE}}, 2'b10, '1, '1, '0, 1'b0);
    for (int i = 0; i < 3; i++) cyc({L{IDLE}}, 2'b10, '1, '1, 4'b0001, 1'b0);
    cyc({L{IDLE}}, 2'b10, '1, '1, '0, 1'b0);
    check("lock_held", 256'(lock), 256'(4'b1111));
    cyc({L{IDLE}}, 2'b10, '1, '1, '0, 1'b0);
    check("lock_drop", 256'(lock), 256'(4'b1110));
    cyc({L{IDLE}}, 2'b10, '1, '1, '0, 1'b0);
    cyc({L{IDLE}}, 2'b10, '1, '1, '0, 1'b0);
    check("err_lane0", 256'(err_cnt), 256'(16'h0006));
    for (int i = 0; i < 6; i++) cyc({L{IDLE}}, 2'b10, '1, '1, '0, 1'b0);
    check("relock", 256'(lock), 256'(4'b1111));

    // One-cycle block-sync loss on lane 0.
    cyc({L{IDLE}}, 2'b10, '1, 4'b1110, '0, 1'b0);
    check("sync_lock", 256'(lock[0]), 256'(1'b0));
    cyc({L{IDLE}}, 2'b10, '1, '1, '0, 1'b0);
    check("sync_dout", 256'(dout[63:0]), 256'(0));
    check("sync_en",   256'(dout_en[0]), 256'(1'b0));
    check("sync_sh",   256'(dout_sh[1:0]), 256'(2'b00));
    for (int i = 0; i < 8; i++) cyc({L{IDLE}}, 2'b10, '1, '1, '0, 1'b0);

    // Bypass: raw data passes through; idle-looking raw words with a dirty payload drop lock.
    dis = 1'b1;
    for (int i = 0; i < 4; i++) cyc({L{IDLE}}, 2'b10, '0, '1, '0, 1'b0);
    byp = 1'b1;
    cyc({L{BYPW}}, 2'b01, '1, '1, '0, 1'b0);
    cyc({L{LOOK}}, 2'b10, '1, '1, '0, 1'b0);
    check("byp_dout", 256'(dout), 256'({L{BYPW}}));
    cyc({L{LOOK}}, 2'b10, '1, '1, '0, 1'b0);
    cyc({L{LOOK}}, 2'b10, '1, '1, '0, 1'b0);
    cyc({L{IDLE}}, 2'b10, '0, '1, '0, 1'b0);
    cyc({L{IDLE}}, 2'b10, '0, '1, '0, 1'b0);
    check("byp_unlock", 256'(lock), 256'(4'b0000));
    dis = 1'b0;
    for (int i = 0; i < 4; i++) cyc({L{IDLE}}, 2'b10, '0, '1, '0, 1'b0);
    byp = 1'b0;
    for (int i = 0; i < 8; i++) cyc({L{IDLE}}, 2'b10, '1, '1, '0, 1'b0);

    // Counter saturation, then clear on the cycle the 20th bad idle is evaluated.
    for (int i = 0; i < 20; i++) cyc({L{BAD}}, 2'b10, '1, '1, '0, 1'b0);
    cyc({L{IDLE}}, 2'b10, '1, '1, '0, 1'b0);
    check("err_sat", 256'(err_cnt), 256'(16'hFFFF));
    cyc({L{IDLE}}, 2'b10, '1, '1, '0, 1'b1);
    check("err_clr", 256'(err_cnt), 256'(16'h0000));
    cyc({L{IDLE}}, 2'b10, '1, '1, '0, 1'b0);

    // Random payloads with per-lane valid gaps.
    for (int i = 0; i < 30; i++) begin
      for (int n = 0; n < L; n++) rp[64*n +: 64] = {$urandom(), $urandom()};
      cyc(rp, ($urandom_range(0, 1) != 0) ? 2'b10 : 2'b01, L'($urandom_range(0, 15)), '1, '0, 1'b0);
    end

    // Independent lane streams with sync dropped on lane 2 only.
    for (int i = 0; i < 20; i++) begin
      for (int n = 0; n < L; n++) rp[64*n +: 64] = {$urandom(), $urandom()};
      cyc(rp, 2'b01, '1, (i == 10) ? 4'b1011 : 4'b1111, '0, 1'b0);
      if (i == 11) begin
        check("lane2_dout", 256'(dout[191:128]), 256'(0));
        check("lane2_en",   256'(dout_en), 256'(4'b1011));
        check("lane2_sh",   256'(dout_sh[5:4]), 256'(2'b00));
      end
    end

    // Reset mid-stream with valid asserted, then restart from the all-ones seed.
    do_reset();
    for (int i = 0; i < 6; i++) cyc({L{IDLE}}, 2'b10, '1, '1, '0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
    $finish;
  end

endmodule
